// File: rtl/sprite_pkg.sv
// sprite_pkg: shared widths, constants and state type for the sprite attribute memory controller
package sprite_pkg;
  localparam int SPRITE_ADDR_W = 8;
  localparam int ATTR_W = 4;
  localparam int SPRITE_DATA_W = 14;
  localparam int MEM_ADDR_W = SPRITE_ADDR_W + ATTR_W;
  localparam logic [ATTR_W-1:0] ATTR_CLEAR = 4'hF;
  typedef enum logic {IDLE, CLEAR} state_t;
  function automatic logic [MEM_ADDR_W-1:0] attr_addr(input logic [SPRITE_ADDR_W-1:0] s, input logic [ATTR_W-1:0] a);
    return {s, a};
  endfunction
endpackage

// File: rtl/sprite_mem_ctrl_if.sv
// sprite_mem_ctrl_if: EX, renderer and memory-side signals of the sprite memory controller
interface sprite_mem_ctrl_if;
  import sprite_pkg::*;
  logic ex_re, ex_we, ex_stall, ex_rvalid;
  logic [SPRITE_ADDR_W-1:0] ex_addr;
  logic [ATTR_W-1:0] ex_action;
  logic [SPRITE_DATA_W-1:0] ex_wdata, ex_rdata;
  logic rd_req, rd_grant, rd_rvalid;
  logic [MEM_ADDR_W-1:0] rd_addr, mem_addr;
  logic [SPRITE_DATA_W-1:0] rd_rdata;
  logic mem_re, mem_we;
  logic [SPRITE_DATA_W-1:0] mem_wdata, mem_rdata;
  modport master (
    output ex_re, ex_we, ex_addr, ex_action, ex_wdata, rd_req, rd_addr, mem_rdata,
    input ex_stall, ex_rdata, ex_rvalid, rd_grant, rd_rdata, rd_rvalid, mem_addr, mem_re, mem_we, mem_wdata
  );
  modport slave (
    input ex_re, ex_we, ex_addr, ex_action, ex_wdata, rd_req, rd_addr, mem_rdata,
    output ex_stall, ex_rdata, ex_rvalid, rd_grant, rd_rdata, rd_rvalid, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/sprite_clear_seq.sv
// sprite_clear_seq: IDLE/CLEAR state and attribute counter for the bulk clear of one sprite
module sprite_clear_seq import sprite_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic step,
  output state_t state,
  output logic [ATTR_W-1:0] cnt,
  output logic done
);
  state_t state_nx;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (step) cnt <= cnt + 1'b1;
    end
  always_comb state_nx = (state == IDLE && start) ? CLEAR : (done ? IDLE : state);
  always_comb done = (state == CLEAR) && step && (cnt == ATTR_CLEAR);
endmodule

// File: rtl/sprite_mem_ctrl.sv
// sprite_mem_ctrl: arbitrates the single-port sprite attribute memory between EX and the renderer,
// with renderer starvation limiting and a multi-cycle bulk clear.
module sprite_mem_ctrl import sprite_pkg::*; #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [SPRITE_DATA_W-1:0] CLEAR_VALUE = '0
) (
  input logic clk,
  input logic rst_n,
  sprite_mem_ctrl_if.slave bus
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt, starve_nx;
  logic ex_tag, rd_tag;
  logic ex_req, pending, clr_cmd, rd_win, ex_win, ex_rd, ex_wr, clr_start, clr_step, clr_done;
  logic [ATTR_W-1:0] clr_cnt;
  state_t state;
  sprite_clear_seq u_clr (
    .clk(clk), .rst_n(rst_n), .start(clr_start), .step(clr_step),
    .state(state), .cnt(clr_cnt), .done(clr_done)
  );
  always_comb begin
    ex_req = bus.ex_re | bus.ex_we;
    pending = ex_req | (state == CLEAR);
    clr_cmd = bus.ex_we & (bus.ex_action == ATTR_CLEAR);
    rd_win = bus.rd_req & ((starve_cnt < LIM) | !pending);
    ex_win = pending & !rd_win;
    clr_start = ex_win & (state == IDLE) & clr_cmd;
    clr_step = ex_win & (state == CLEAR);
    ex_wr = ex_win & (state == IDLE) & bus.ex_we & !clr_cmd;
    ex_rd = ex_win & (state == IDLE) & !bus.ex_we;
    starve_nx = (rd_win & pending) ? ((starve_cnt == LIM) ? starve_cnt : starve_cnt + 4'd1) : '0;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      starve_cnt <= '0;
      ex_tag <= 1'b0;
      rd_tag <= 1'b0;
    end else begin
      starve_cnt <= starve_nx;
      ex_tag <= ex_rd;
      rd_tag <= rd_win;
    end
  // Read data is the memory's output steered by which port was granted last cycle.
  always_comb begin
    bus.rd_grant = rd_win;
    bus.mem_re = rd_win | ex_rd;
    bus.mem_we = ex_wr | clr_step;
    bus.mem_addr = rd_win ? bus.rd_addr
                 : (ex_rd | ex_wr | clr_step) ? attr_addr(bus.ex_addr, (state == CLEAR) ? clr_cnt : bus.ex_action)
                 : '0;
    bus.mem_wdata = clr_step ? CLEAR_VALUE : (ex_wr ? bus.ex_wdata : '0);
    bus.ex_stall = pending & !(ex_win & ((state == IDLE) ? !clr_cmd : clr_done));
    bus.ex_rvalid = ex_tag;
    bus.ex_rdata = ex_tag ? bus.mem_rdata : '0;
    bus.rd_rvalid = rd_tag;
    bus.rd_rdata = rd_tag ? bus.mem_rdata : '0;
  end
endmodule

// File: doc/sprite_mem_ctrl.md
# sprite_mem_ctrl

Arbiter and sequencer for the single-port sprite attribute memory, shared between the EX stage's sprite path and the display renderer's fetch port. Each cycle it grants at most one requester, forms the 12-bit memory address from sprite index and attribute, returns read data one cycle later, and stalls EX while its request is pending. It also runs a multi-cycle bulk clear of all 16 attributes of one sprite on an EX clear command.

## Interface
- STARVE_LIMIT, 4: max consecutive renderer grants while EX waits; range 1..15
- CLEAR_VALUE, 14'h0000: data written by bulk clear
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ex_re  in  1  EX sprite read request
- ex_we  in  1  EX sprite write request; wins over ex_re if both high
- ex_addr  in  8  sprite index
- ex_action  in  4  attribute index; 4'hF with ex_we = bulk clear command
- ex_wdata  in  14  EX write data
- ex_stall  out  1  EX must hold all ex_* inputs stable
- ex_rdata  out  14  EX read data
- ex_rvalid  out  1  ex_rdata valid, one-cycle pulse
- rd_req  in  1  renderer read request
- rd_addr  in  12  renderer address {sprite, attr}
- rd_grant  out  1  renderer request accepted this cycle
- rd_rdata  out  14  renderer read data
- rd_rvalid  out  1  rd_rdata valid, one-cycle pulse
- mem_addr  out  12  memory address
- mem_re, mem_we  out  1 each  memory strobes, never both high
- mem_wdata  out  14  memory write data
- mem_rdata  in  14  memory read data, valid the cycle after mem_re

## Operation
- States: IDLE, CLEAR. Reset: IDLE; all outputs 0; starvation counter 0; clear counter 0.
- IDLE, EX address = {ex_addr, ex_action}.
- Grant rule per cycle: renderer wins when rd_req and starve_cnt < STARVE_LIMIT; otherwise EX wins if requesting; else renderer if requesting; else memory idle.
- starve_cnt increments on each renderer grant while an EX request (or clear step) is pending; clears to 0 on any EX grant or when EX not requesting. Saturates at STARVE_LIMIT.
- EX grant of write (ex_action != 4'hF): mem_we=1, write complete at that edge.
- EX grant of read: mem_re=1; ex_rvalid and ex_rdata next cycle.
- ex_we with ex_action==4'hF in IDLE: enter CLEAR next cycle on first EX-slot grant; writes CLEAR_VALUE to {ex_addr, 4'h0} .. {ex_addr, 4'hF}, one address per EX-slot grant; clear counter wraps 15->0 and returns to IDLE.
- Renderer continues to be arbitrated during CLEAR under the same rule.
- ex_stall = EX request present and (not granted this cycle, or clear not finishing this cycle). Read grant drops stall in grant cycle; EX advances, data arrives next cycle.
- Read-after-write across cycles returns new data (grant order = memory order).

## Timing
- Read latency: grant at cycle N, rvalid/rdata at N+1, exactly one cycle, no bubbles; back-to-back reads on either port sustain 1/cycle.
- rd_grant, ex_stall, mem_* combinational from current inputs and state; rvalid/rdata registered (mem_rdata steered by registered 1-bit tag).
- Clear with no renderer traffic: 16 cycles of writes, ex_stall high for first 15 plus entry; stall low in cycle of 16th write.
- Worst-case EX wait: STARVE_LIMIT cycles.
- Reset mid-clear: returns to IDLE at that edge, pending rvalid suppressed, memory contents not restored.

## Structure
- Shared package sprite_pkg: SPRITE_ADDR_W=8, ATTR_W=4, SPRITE_DATA_W=14, ATTR_CLEAR=4'hF, state enum {IDLE, CLEAR}.
- One sub-module natural: sprite_clear_seq (clear counter, CLEAR state, done pulse); arbitration and return steering in top.

## Test plan
- EX write 14'h1234 to sprite 8'h05 attr 3, then read -> mem_addr 12'h053, ex_rvalid next cycle with 14'h1234, no stall.
- rd_req held high, EX read pending, STARVE_LIMIT=4 -> 4 renderer grants, 5th cycle EX granted, ex_stall low that cycle.
- ex_re and ex_we both high, action 2 -> treated as write only, mem_re=0, no ex_rvalid.
- Clear of sprite 8'hA0 with idle renderer -> mem_we at 12'hA00..12'hA0F over 16 consecutive cycles, data 0, then IDLE; readback of 12'hA07 returns 0.
- Clear with renderer requesting every cycle, STARVE_LIMIT=2 -> pattern 2 renderer grants / 1 clear write, clear completes after 48 cycles.
- rst_n low at clear step 7 -> next cycle IDLE, all outputs 0, ex_stall low, no further mem_we.
